// File: rtl/any1_branch_update_queue.sv
// Branch-resolution update queue feeding the gselect predictor.
// Define ANY1_BUQ_STATS_EN to enable the saturating dropped-update counter.
module any1_branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          en,
    input  logic          clr,
    input  logic          wr,
    input  logic [31:0]   wip,
    input  logic          wtakb,
    output logic          xisBranch,
    output logic [31:0]   xip,
    output logic          takb,
    output logic          full,
    output logic [AW:0]   count,
    output logic [15:0]   drop_cnt
);

    logic [32:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_d;
    logic        valid_q, valid_d;
    logic [31:0] xip_q, xip_d;
    logic        takb_q, takb_d;
    logic        pop, push;

    assign count = wptr_q - rptr_q;
    assign full  = (count == (AW+1)'(DEPTH));

    // The presented entry is consumed on the edge that ends its valid cycle.
    always_comb begin
        pop     = valid_q;
        push    = wr && !clr && (!full || pop);
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count;
        valid_d = 1'b0;
        xip_d   = xip_q;
        takb_d  = takb_q;
        if (clr) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            rptr_d  = rptr_q + {{AW{1'b0}}, pop};
            wptr_d  = wptr_q + {{AW{1'b0}}, push};
            count_d = wptr_d - rptr_d;
            valid_d = en && (count_d != '0);
            // New head is either the entry being written now or one already stored.
            if (count_d != '0) begin
                if (push && (rptr_d == wptr_q)) begin
                    xip_d  = wip;
                    takb_d = wtakb;
                end else begin
                    {xip_d, takb_d} = mem_q[rptr_d[AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
            xip_q   <= '0;
            takb_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            xip_q   <= xip_d;
            takb_q  <= takb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {wip, wtakb};
        end
    end

    assign xisBranch = valid_q;
    assign xip       = xip_q;
    assign takb      = takb_q;

`ifdef ANY1_BUQ_STATS_EN
    logic        drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A clr-killed write is a flush, not a discard, so it is not counted.
    always_comb begin
        drop       = wr && !clr && full && !pop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_any1_branch_update_queue.sv
// Scoreboard bench for any1_branch_update_queue: queue-level reference model plus output monitor.
module tb_any1_branch_update_queue;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          rst, clk, en, clr, wr, wtakb;
    logic [31:0]   wip;
    logic          xisBranch, takb, full;
    logic [31:0]   xip;
    logic [AW:0]   count;
    logic [15:0]   drop_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    any1_branch_update_queue #(.DEPTH(DEPTH)) dut (
        .rst(rst), .clk(clk), .en(en), .clr(clr), .wr(wr), .wip(wip), .wtakb(wtakb),
        .xisBranch(xisBranch), .xip(xip), .takb(takb), .full(full), .count(count),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue contents, what is on the outputs, and the scoreboard
    logic [32:0] mq[$];
    logic [32:0] sb[$];
    logic        m_valid;
    logic [32:0] m_head;
    int          m_drop;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // The consumer takes whatever was shown during the cycle that this edge ends.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            sb.delete();
            m_valid = 1'b0;
            m_head  = '0;
            m_drop  = 0;
        end else if (clr) begin
            mq.delete();
            sb.delete();
            m_valid = 1'b0;
        end else begin
            if (m_valid) void'(mq.pop_front());
            if (wr) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({wip, wtakb});
                    sb.push_back({wip, wtakb});
                end else if (m_drop < 16'hFFFF) begin
                    m_drop++;
                end
            end
            if (mq.size() > 0) m_head = mq[0];
            m_valid = en && (mq.size() > 0);
        end
    end

    // Monitor: compares on the falling edge, away from state changes.
    always @(negedge clk) begin
        logic [32:0] e;
        check_output("xisBranch", 64'(xisBranch), 64'(m_valid));
        check_output("count", 64'(count), 64'(mq.size()));
        check_output("full", 64'(full), 64'(mq.size() == DEPTH));
        check_output("head_hold", {31'd0, xip, takb}, 64'(m_head));
`ifdef ANY1_BUQ_STATS_EN
        check_output("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`else
        check_output("drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        if (xisBranch) begin
            if (sb.size() == 0) begin
                check_output("unexpected_update", {31'd0, xip, takb}, 64'hDEAD);
            end else begin
                e = sb.pop_front();
                check_output("update_order", {31'd0, xip, takb}, 64'(e));
            end
        end
    end

    task automatic apply_stimulus(input logic e, input logic c, input logic w,
                                  input logic [31:0] ip, input logic t);
        @(negedge clk);
        #1;
        en = e; clr = c; wr = w; wip = ip; wtakb = t;
    endtask

    task automatic idle(input logic e, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(e, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; wr = 1'b0; wip = '0; wtakb = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Single update appears for exactly one cycle
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0000_1008, 1'b1);
        idle(1'b1, 3);

        // Fill while disabled, overflow once, then drain in order
        for (int i = 0; i < DEPTH + 1; i++)
            apply_stimulus(1'b0, 1'b0, 1'b1, 32'h2000 + 32'(i * 4), i[0]);
        idle(1'b0, 2);
        idle(1'b1, DEPTH + 3);

        // Full queue under sustained simultaneous push and pop
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(i * 4), 1'b1);
        idle(1'b1, 1);
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b1, 1'b0, 1'b1, 32'h4000 + 32'(i * 4), i[0]);
        idle(1'b1, DEPTH + 3);

        // Flush with a colliding write
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b0, 1'b0, 1'b1, 32'h5000 + 32'(i * 4), 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h5FFC, 1'b1);
        idle(1'b1, 4);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b0, 1'b0, 1'b1, 32'h6000 + 32'(i * 4), 1'b1);
        idle(1'b1, 2);
        #2 rst = 1'b1;
        #1;
        check_output("rst_xisBranch", 64'(xisBranch), 64'd0);
        check_output("rst_xip", 64'(xip), 64'd0);
        check_output("rst_count", 64'(count), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(1'b1, 4);

        // Pointer wrap with alternating direction
        for (int i = 0; i < 3 * DEPTH + 3; i++)
            apply_stimulus(1'b1, 1'b0, 1'b1, 32'h7000 + 32'(i * 4), ~i[0]);
        idle(1'b1, DEPTH + 3);

        // Random traffic
        for (int i = 0; i < 400; i++)
            apply_stimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                           ($urandom_range(0, 9) < 6), $urandom, 1'($urandom));
        idle(1'b1, DEPTH + 3);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/any1_branch_update_queue.md
ANY1_BRANCH_UPDATE_QUEUE -- requirements
Module: any1_branch_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, 2..64).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), pointer width.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port en  input  1  predictor enable; entries drain only while high.
REQ-006 SHALL have port clr  input  1  synchronous queue flush.
REQ-007 SHALL have port wr  input  1  execute stage resolved a branch this cycle.
REQ-008 SHALL have port wip  input  32  IP of resolved branch.
REQ-009 SHALL have port wtakb  input  1  resolved direction, 1 = taken.
REQ-010 SHALL have port xisBranch  output  1  update valid to gselect predictor.
REQ-011 SHALL have port xip  output  32  IP of the update.
REQ-012 SHALL have port takb  output  1  direction of the update.
REQ-013 SHALL have port full  output  1  DEPTH entries held.
REQ-014 SHALL have port count  output  AW+1  occupied entries.
REQ-015 SHALL have port drop_cnt  output  16  dropped-update count (see Configuration).

Function
REQ-016 SHALL be a FIFO of {wip, wtakb} entries with read/write pointers of AW+1 bits; pointers wrap modulo DEPTH, MSB distinguishes full from empty.
REQ-017 SHALL push on wr when not full, or when full and a pop occurs in the same cycle.
REQ-018 SHALL discard the write (no state change) on wr while full with no concurrent pop.
REQ-019 SHALL register outputs: xisBranch = en && !empty, xip/takb = head entry; a pushed entry is presented no earlier than the cycle after the push (1-cycle latency, no bypass).
REQ-020 SHALL pop the head on every rising edge where xisBranch is high; the predictor consumes unconditionally, no ready signal.
REQ-021 SHALL hold xisBranch low and retain all entries while en is low; a write in that window still enqueues.
REQ-022 SHALL on simultaneous push and pop keep count unchanged and preserve FIFO order.
REQ-023 SHALL on clr empty the queue next cycle, drop any same-cycle wr, and force xisBranch low that cycle; clr has priority over wr and pop.
REQ-024 SHALL drive full = (count == DEPTH) and count = wptr - rptr, both registered-consistent with xisBranch.
REQ-025 SHALL keep xip/takb stable whenever xisBranch is low (no glitching to unrelated entries) until next pop or push-to-empty.

Reset
REQ-026 SHALL on rst clear both pointers, xisBranch=0, xip=0, takb=0, full=0, count=0, drop_cnt=0, asynchronously.
REQ-027 SHALL discard in-flight entries if rst asserts mid-operation; storage array contents need not be reset.
REQ-028 SHALL ignore wr on the first edge after rst deasserts only if rst was still high at that edge.

Configuration
REQ-029 SHALL with macro ANY1_BUQ_STATS_EN defined increment drop_cnt on each REQ-018 discard, saturating at 16'hFFFF, cleared by rst only (not clr).
REQ-030 SHALL with ANY1_BUQ_STATS_EN undefined tie drop_cnt to 16'h0000 with no counter logic.

Verification
REQ-031 SHALL cover: en=1, wr once with wip=32'h0000_1008,wtakb=1 -> next cycle xisBranch=1,xip=32'h0000_1008,takb=1, following cycle xisBranch=0.
REQ-032 SHALL cover: en=0, 8 writes (DEPTH=8) -> full=1,count=8; 9th write dropped, drop_cnt=1 with STATS_EN; then en=1 -> 8 consecutive updates in write order, count reaches 0.
REQ-033 SHALL cover: full queue, en=1, wr every cycle for 20 cycles -> count stays 8, no drops, outputs ordered.
REQ-034 SHALL cover: 5 entries queued, clr=1 with wr=1 -> next cycle count=0, xisBranch=0, written entry not delivered.
REQ-035 SHALL cover: rst asserted asynchronously mid-drain with 3 entries -> outputs zero immediately, no update presented after deassert until new write.
REQ-036 SHALL cover: pointer wrap, 3*DEPTH+3 alternating-taken pushes/pops -> every update delivered once, in order, takb pattern 1,0,1,...
